keypad_scanner: RTL and testbench

- Scans a 4x3 matrix keypad, debounces it, and presents one stable key to the countdown timer.
- Output `keypad[9:0]` is the one-hot digit bus the timer reads; the timer detects a press on the rising edge of that bus.
- Also reports `*` and `#` and a one-cycle press strobe for other consumers.
- Runs on the 1 kHz system tick clock; sits between the board keypad pins and the timer/clock blocks.

---
 rtl/keypad_scanner.sv | 205 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x3 matrix keypad, debounces whole scans, and presents one stable
// committed key to the countdown timer (one-hot digit bus) and to other
// consumers (star/hash flags, 4-bit key code and a one-cycle press strobe).
// Runs in the 1 kHz system tick domain.
//
// Ports:
//   clk        in   1   system clock (1 kHz tick domain)
//   rst        in   1   synchronous, active-high reset
//   key_col    in   3   column pins, active-low, pulled up, asynchronous
//   key_row    out  4   row drive, active-low, exactly one bit low
//   keypad     out  10  one-hot committed digit (bit n = digit n, 0 = none)
//   key_star   out  1   committed key is '*'
//   key_hash   out  1   committed key is '#'
//   key_code   out  4   committed key: 0-9 digit, 10 '*', 11 '#', 15 none
//   key_press  out  1   one-cycle strobe when committed key becomes non-none
//
// Key map (row: col0 col1 col2):
//   r0: 1 2 3   r1: 4 5 6   r2: 7 8 9   r3: * 0 #
// Scan vector bit index is row*3 + col.
// ---------------------------------------------------------------------------
module keypad_scanner #(
  parameter int ROW_HOLD       = 4,  // cycles per row; >= 3 for the 2-FF sync
  parameter int DEBOUNCE_SCANS = 3   // identical scans before commit (1..15)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_col,
  output logic [3:0] key_row,
  output logic [9:0] keypad,
  output logic       key_star,
  output logic       key_hash,
  output logic [3:0] key_code,
  output logic       key_press
);

  localparam int             PW         = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;
  localparam logic [PW-1:0]  PHASE_LAST = PW'(ROW_HOLD - 1);
  localparam logic [3:0]     DEB_N      = 4'(DEBOUNCE_SCANS);
  localparam logic [3:0]     CODE_NONE  = 4'd15;
  localparam logic [3:0]     CODE_STAR  = 4'd10;
  localparam logic [3:0]     CODE_HASH  = 4'd11;

  // Scan vector position (row*3 + col) to key code.
  function automatic logic [3:0] idx_to_code(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd9:    code = CODE_STAR;
      4'd10:   code = 4'd0;
      4'd11:   code = CODE_HASH;
      default: code = (idx <= 4'd8) ? idx + 4'd1 : CODE_NONE;
    endcase
    return code;
  endfunction

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic [1:0]    row_q, row_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [3:0]    key_row_q, key_row_d;
  logic [11:0]   scan_vec_q, scan_vec_d;
  logic          scan_done_q, scan_done_d;
  logic [3:0]    match_q, match_d;
  logic [3:0]    prev_q, prev_d;
  logic [3:0]    commit_q, commit_d;
  logic [9:0]    keypad_q, keypad_d;
  logic          star_q, star_d;
  logic          hash_q, hash_d;
  logic          press_q, press_d;

  // -------------------------------------------------------------------------
  // Scan vector decode: exactly one key down gives its code; none or several
  // (multi-press or ghosting through the matrix) give CODE_NONE.
  // -------------------------------------------------------------------------
  logic [3:0] hit_cnt;
  logic [3:0] hit_idx;
  logic [3:0] cand;

  always_comb begin
    hit_cnt = '0;
    hit_idx = '0;
    for (int i = 0; i < 12; i++) begin
      if (scan_vec_q[i]) begin
        hit_cnt = hit_cnt + 4'd1;
        hit_idx = 4'(i);
      end
    end
    cand = (hit_cnt == 4'd1) ? idx_to_code(hit_idx) : CODE_NONE;
  end

  // Synchronized columns, inverted so that 1 = pressed.
  logic [2:0] col_pressed;
  assign col_pressed = ~sync2_q;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path through
    // this block can leave a signal unassigned and infer a latch.
    sync1_d     = key_col;
    sync2_d     = sync1_q;
    row_d       = row_q;
    phase_d     = phase_q;
    scan_vec_d  = scan_vec_q;
    scan_done_d = 1'b0;
    match_d     = match_q;
    prev_d      = prev_q;
    commit_d    = commit_q;
    press_d     = 1'b0;

    // Evaluation cycle: the scan just completed is judged and the vector is
    // cleared. The clear comes before sampling below so a sample landing on
    // the same edge (only possible with a 1-cycle row hold) is kept.
    if (scan_done_q) begin
      scan_vec_d = '0;
      if (cand == prev_q) begin
        match_d = (match_q >= DEB_N) ? DEB_N : match_q + 4'd1;
      end else begin
        prev_d  = cand;
        match_d = 4'd1;
      end
      if ((match_d == DEB_N) && (cand != commit_q)) begin
        commit_d = cand;
        press_d  = (cand != CODE_NONE);
      end
    end

    // Row timing: the columns are sampled on the last phase of each row,
    // after the new row drive has propagated through both sync stages.
    if (phase_q == PHASE_LAST) begin
      phase_d = '0;
      row_d   = row_q + 2'd1;
      case (row_q)
        2'd0:    scan_vec_d[2:0]  = col_pressed;
        2'd1:    scan_vec_d[5:3]  = col_pressed;
        2'd2:    scan_vec_d[8:6]  = col_pressed;
        default: scan_vec_d[11:9] = col_pressed;
      endcase
      scan_done_d = (row_q == 2'd3);
    end else begin
      phase_d = phase_q + PW'(1);
    end

    // Row drive tracks the next row index so it changes on the advance edge.
    key_row_d = ~(4'b0001 << row_d);

    // Committed-key outputs are all registered from the next committed code.
    keypad_d = (commit_d <= 4'd9) ? (10'd1 << commit_d) : '0;
    star_d   = (commit_d == CODE_STAR);
    hash_d   = (commit_d == CODE_HASH);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here, so every register loads from
    // values settled before the edge regardless of statement order.
    if (rst) begin
      sync1_q     <= 3'b111;
      sync2_q     <= 3'b111;
      row_q       <= 2'd0;
      phase_q     <= '0;
      key_row_q   <= 4'b1110;
      scan_vec_q  <= '0;
      scan_done_q <= 1'b0;
      match_q     <= 4'd0;
      prev_q      <= CODE_NONE;
      commit_q    <= CODE_NONE;
      keypad_q    <= '0;
      star_q      <= 1'b0;
      hash_q      <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      row_q       <= row_d;
      phase_q     <= phase_d;
      key_row_q   <= key_row_d;
      scan_vec_q  <= scan_vec_d;
      scan_done_q <= scan_done_d;
      match_q     <= match_d;
      prev_q      <= prev_d;
      commit_q    <= commit_d;
      keypad_q    <= keypad_d;
      star_q      <= star_d;
      hash_q      <= hash_d;
      press_q     <= press_d;
    end
  end

  assign key_row   = key_row_q;
  assign keypad    = keypad_q;
  assign key_star  = star_q;
  assign key_hash  = hash_q;
  assign key_code  = commit_q;
  assign key_press = press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//
// Self-checking bench for keypad_scanner. A behavioural keypad matrix drives
// key_col from key_row and a set of held keys. Expected press strobes are
// queued when a key is pressed and popped when the DUT strobes. Timing points
// are counted in clock edges from the most recent reset edge (edge 0).
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] key_col;
  logic [3:0] key_row;
  logic [9:0] keypad;
  logic       key_star;
  logic       key_hash;
  logic [3:0] key_code;
  logic       key_press;

  logic [11:0] keys = '0;       // held keys, index row*3 + col
  logic [15:0] outs;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;    // edges since the last reset edge
  int          exp_q[$];        // expected committed codes, one per strobe

  always #5 clk = ~clk;

  keypad_scanner dut (
    .clk      (clk),
    .rst      (rst),
    .key_col  (key_col),
    .key_row  (key_row),
    .keypad   (keypad),
    .key_star (key_star),
    .key_hash (key_hash),
    .key_code (key_code),
    .key_press(key_press)
  );

  // Matrix model: a held key pulls its column low while its row is driven.
  always_comb begin
    key_col = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!key_row[r] && keys[r*3 + c]) key_col[c] = 1'b0;
  end

  assign outs = {keypad, key_star, key_hash, key_code};

  function automatic int key_idx(input int code);
    case (code)
      0:       return 10;
      10:      return 9;
      11:      return 11;
      default: return code - 1;
    endcase
  endfunction

  function automatic logic [15:0] exp_out(input int code);
    logic [9:0] kp;
    kp = '0;
    if (code >= 0 && code <= 9) kp[code] = 1'b1;
    return {kp, (code == 10), (code == 11), 4'(code)};
  endfunction

  // One clock edge; outputs sampled 1 time unit later. Any strobe is matched
  // against the scoreboard here.
  task automatic tick();
    int exp;
    @(posedge clk);
    #1;
    cyc++;
    if (key_press === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: key_press high at edge %0d with key_code=%0d, none expected",
                 cyc, key_code);
      end else begin
        exp = exp_q.pop_front();
        if (outs !== exp_out(exp)) begin
          n_fail++;
          $display("FAIL strobe_value: outputs %h at edge %0d, required %h (key %0d)",
                   outs, cyc, exp_out(exp), exp);
        end
      end
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic press_key(input int code);
    keys[key_idx(code)] = 1'b1;
  endtask

  task automatic release_key(input int code);
    keys[key_idx(code)] = 1'b0;
  endtask

  task automatic strobes_done(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_strobes: %0d expected strobes not seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    keys = '0;
    do_reset();
    n_checks++;
    if (outs !== exp_out(15) || key_row !== 4'b1110 || key_press !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: outs=%h row=%b press=%b, required outs=%h row=1110 press=0",
               outs, key_row, key_press, exp_out(15));
    end
    for (int k = 1; k <= 100; k++) begin
      tick();
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      n_checks++;
      if (key_row !== exp_row || key_press !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_scan: edge %0d row=%b press=%b, required row=%b press=0",
                 k, key_row, key_press, exp_row);
      end
    end
    n_checks++;
    if (outs !== exp_out(15)) begin
      n_fail++;
      $display("FAIL idle_outputs: outs=%h, required %h", outs, exp_out(15));
    end
    strobes_done("reset");
  endtask

  task automatic test_hold_5();
    keys = '0;
    do_reset();
    press_key(5);
    exp_q.push_back(5);
    goto(48);
    n_checks++;
    if (outs !== exp_out(15)) begin
      n_fail++; $display("FAIL hold5_early: outs=%h, required %h", outs, exp_out(15));
    end
    goto(49);
    n_checks++;
    if (outs !== exp_out(5) || key_press !== 1'b1) begin
      n_fail++; $display("FAIL hold5_commit: outs=%h press=%b, required %h press=1", outs, key_press, exp_out(5));
    end
    goto(50);
    n_checks++;
    if (key_press !== 1'b0) begin
      n_fail++; $display("FAIL hold5_pulse_width: press=%b, required 0", key_press);
    end
    goto(97);
    n_checks++;
    if (outs !== exp_out(5)) begin
      n_fail++; $display("FAIL hold5_held: outs=%h, required %h", outs, exp_out(5));
    end
    release_key(5);
    goto(144);
    n_checks++;
    if (outs !== exp_out(5)) begin
      n_fail++; $display("FAIL hold5_release_early: outs=%h, required %h", outs, exp_out(5));
    end
    goto(145);
    n_checks++;
    if (outs !== exp_out(15) || key_press !== 1'b0) begin
      n_fail++; $display("FAIL hold5_release: outs=%h press=%b, required %h press=0", outs, key_press, exp_out(15));
    end
    strobes_done("hold5");
  endtask

  task automatic test_bounce_7();
    keys = '0;
    do_reset();
    press_key(7);
    exp_q.push_back(7);
    goto(20);
    release_key(7);               // bounce covers the row-2 sample of scan 2
    goto(30);
    press_key(7);
    goto(49);
    n_checks++;
    if (outs !== exp_out(15)) begin
      n_fail++; $display("FAIL bounce7_no_partial: outs=%h, required %h", outs, exp_out(15));
    end
    goto(80);
    n_checks++;
    if (outs !== exp_out(15)) begin
      n_fail++; $display("FAIL bounce7_early: outs=%h, required %h", outs, exp_out(15));
    end
    goto(81);
    n_checks++;
    if (outs !== exp_out(7)) begin
      n_fail++; $display("FAIL bounce7_commit: outs=%h, required %h", outs, exp_out(7));
    end
    goto(90);
    release_key(7);
    strobes_done("bounce7");
  endtask

  task automatic test_multi_key();
    keys = '0;
    do_reset();
    press_key(1);
    press_key(9);
    goto(82);
    n_checks++;
    if (outs !== exp_out(15)) begin
      n_fail++; $display("FAIL multi_reject: outs=%h, required %h", outs, exp_out(15));
    end
    release_key(9);
    exp_q.push_back(1);
    goto(128);
    n_checks++;
    if (outs !== exp_out(15)) begin
      n_fail++; $display("FAIL multi_early: outs=%h, required %h", outs, exp_out(15));
    end
    goto(129);
    n_checks++;
    if (outs !== exp_out(1)) begin
      n_fail++; $display("FAIL multi_commit1: outs=%h, required %h", outs, exp_out(1));
    end
    release_key(1);
    strobes_done("multi");
  endtask

  task automatic test_star_hash();
    keys = '0;
    do_reset();
    press_key(10);
    exp_q.push_back(10);
    goto(49);
    n_checks++;
    if (outs !== exp_out(10)) begin
      n_fail++; $display("FAIL star_commit: outs=%h, required %h", outs, exp_out(10));
    end
    release_key(10);
    press_key(11);
    exp_q.push_back(11);
    goto(96);
    n_checks++;
    if (outs !== exp_out(10)) begin
      n_fail++; $display("FAIL star_held: outs=%h, required %h", outs, exp_out(10));
    end
    goto(97);
    n_checks++;
    if (outs !== exp_out(11) || key_press !== 1'b1) begin
      n_fail++; $display("FAIL hash_commit: outs=%h press=%b, required %h press=1", outs, key_press, exp_out(11));
    end
    release_key(11);
    strobes_done("star_hash");
  endtask

  task automatic test_reset_mid_qualify();
    keys = '0;
    do_reset();
    press_key(3);
    goto(24);                     // inside the second qualifying scan
    do_reset();
    n_checks++;
    if (outs !== exp_out(15) || key_row !== 4'b1110 || key_press !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_values: outs=%h row=%b press=%b, required outs=%h row=1110 press=0",
               outs, key_row, key_press, exp_out(15));
    end
    exp_q.push_back(3);
    goto(48);
    n_checks++;
    if (outs !== exp_out(15)) begin
      n_fail++; $display("FAIL midreset_early: outs=%h, required %h", outs, exp_out(15));
    end
    goto(49);
    n_checks++;
    if (outs !== exp_out(3)) begin
      n_fail++; $display("FAIL midreset_commit: outs=%h, required %h", outs, exp_out(3));
    end
    release_key(3);
    strobes_done("midreset");
  endtask

  initial begin
    test_reset();
    test_hold_5();
    test_bounce_7();
    test_multi_key();
    test_star_hash();
    test_reset_mid_qualify();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
